srl16_fifo: RTL and testbench

//  Ready/valid FIFO that uses WIDTH_P SRL16E shift-register cells as storage, plus one registered output stage.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/srl16_fifo_srl.sv | 25 ++
 rtl/srl16_fifo.sv | 77 +++++++
 tb/tb_srl16_fifo.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the SRL16-based FIFO: SRL cell geometry and occupancy width.
package fifo_pkg;

  localparam int SRL_MAX_DEPTH = 16;
  localparam int SRL_ADDR_W    = 4;

  // Occupancy must represent 0..depth+1 (SRL entries plus the output register).
  function automatic int occ_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/srl16_fifo_srl.sv
// WIDTH_P SRL16E-equivalent cells (INIT=0, rising-edge clock) sharing CE and A3..A0.
module srl16_fifo_srl
  import fifo_pkg::*;
#(
  parameter int WIDTH_P = 8
) (
  input  logic                  clk_i,
  input  logic                  ce_i,
  input  logic [SRL_ADDR_W-1:0] addr_i,
  input  logic [WIDTH_P-1:0]    d_i,
  output logic [WIDTH_P-1:0]    q_o
);

  for (genvar b = 0; b < WIDTH_P; b++) begin : g_srl
    // No reset: contents carry no meaning while the FIFO's SRL count is zero.
    logic [SRL_MAX_DEPTH-1:0] sr;

    always_ff @(posedge clk_i) begin
      if (ce_i) sr <= {sr[SRL_MAX_DEPTH-2:0], d_i[b]};
    end

    assign q_o[b] = sr[addr_i];
  end

endmodule

// File: rtl/srl16_fifo.sv
// Ready/valid FIFO: DEPTH_P entries in SRL cells plus one registered output stage.
module srl16_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [WIDTH_P-1:0]            data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [WIDTH_P-1:0]            data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [occ_w(SRL_MAX_DEPTH)-1:0] count_o
);

  localparam int CNT_W = occ_w(SRL_MAX_DEPTH);

  if (DEPTH_P < 2 || DEPTH_P > SRL_MAX_DEPTH) begin : g_bad_depth
    $error("srl16_fifo: DEPTH_P must be within 2..16");
  end

  logic [CNT_W-1:0]      count_q;
  logic                  valid_q;
  logic [WIDTH_P-1:0]    data_q;
  logic [WIDTH_P-1:0]    srl_q;
  logic [SRL_ADDR_W-1:0] srl_addr;
  logic                  push, load_out, srl_empty, bypass, srl_ce, srl_pop;

  assign ready_o   = (count_q < CNT_W'(DEPTH_P));
  assign push      = valid_i & ready_o;
  assign load_out  = ~valid_q | ready_i;
  assign srl_empty = (count_q == '0);
  assign bypass    = push & load_out & srl_empty;
  assign srl_ce    = push & ~bypass;
  assign srl_pop   = load_out & ~srl_empty;
  // Oldest entry lives at count_q-1; Q is read before the shift on this edge.
  assign srl_addr  = count_q[SRL_ADDR_W-1:0] - SRL_ADDR_W'(1);

  srl16_fifo_srl #(
    .WIDTH_P (WIDTH_P)
  ) u_srl (
    .clk_i  (clk_i),
    .ce_i   (srl_ce),
    .addr_i (srl_addr),
    .d_i    (data_i),
    .q_o    (srl_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      count_q <= count_q + CNT_W'(srl_ce) - CNT_W'(srl_pop);
      if (load_out) begin
        if (bypass) begin
          data_q  <= data_i;
          valid_q <= 1'b1;
        end else if (srl_pop) begin
          data_q  <= srl_q;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q + CNT_W'(valid_q);

endmodule

// File: tb/tb_srl16_fifo.sv
// Scoreboard bench for srl16_fifo: directed scenarios plus a long random ready/valid run.
module tb_srl16_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [4:0] count_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  srl16_fifo #(.WIDTH_P(8), .DEPTH_P(16)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven: check state
  // against the model, account for this cycle's handshakes, advance one cycle.
  task automatic step();
    int sz;
    logic [7:0] exp_d;
    sz = sb.size();
    chk("valid_o", {31'd0, valid_o}, {31'd0, sz > 0});
    chk("count_o", {27'd0, count_o}, sz);
    chk("ready_o", {31'd0, ready_o}, {31'd0, sz < 17});
    chk("invariant", {31'd0, (dut.count_q != 0) && !valid_o}, 32'd0);
    if (valid_o && ready_i) begin
      if (sz == 0) chk("pop_underflow", 32'd1, 32'd0);
      else begin
        exp_d = sb.pop_front();
        chk("data_o", {24'd0, data_o}, {24'd0, exp_d});
      end
    end
    if (valid_i && (sz < 17)) sb.push_back(data_i);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    sb.delete();
    @(negedge clk_i);
  endtask

  initial begin
    do_reset();

    // Reset state, then bypass latency
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_count", {27'd0, count_o}, 32'd0);
    valid_i = 1'b1; data_i = 8'hA5;
    step();
    valid_i = 1'b0;
    chk("byp_valid", {31'd0, valid_o}, 32'd1);
    chk("byp_data", {24'd0, data_o}, 32'hA5);
    chk("byp_count", {27'd0, count_o}, 32'd1);
    chk("byp_count_q", {27'd0, dut.count_q}, 32'd0);

    // Fill to capacity, then one rejected beat
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      valid_i = 1'b1; data_i = 8'(i);
      step();
    end
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    chk("full_count", {27'd0, count_o}, 32'd17);
    data_i = 8'h55; ready_i = 1'b0;
    step();
    chk("full_reject", {27'd0, count_o}, 32'd17);
    ready_i = 1'b1;
    chk("full_ready_i1", {31'd0, ready_o}, 32'd0);

    // Drain from full
    valid_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("drain_seq", {24'd0, data_o}, 32'(i + 1));
      step();
    end
    chk("drain_valid", {31'd0, valid_o}, 32'd0);
    chk("drain_count", {27'd0, count_o}, 32'd0);
    ready_i = 1'b1;
    step();
    chk("empty_hold", {24'd0, data_o}, 32'h11);

    // Steady streaming at 9 entries
    do_reset();
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h40 + i);
      step();
    end
    ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_i = 8'(8'h49 + i);
      step();
      chk("stream_count", {27'd0, count_o}, 32'd9);
    end

    // Asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = 8'(8'h70 + i);
      step();
    end
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_count", {27'd0, count_o}, 32'd0);
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b1; data_i = 8'h3C; ready_i = 1'b0;
    step();
    valid_i = 1'b0;
    chk("arst_byp_data", {24'd0, data_o}, 32'h3C);
    chk("arst_byp_cq", {27'd0, dut.count_q}, 32'd0);

    // Random traffic, fill-biased then drain-biased
    for (int i = 0; i < 10000; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 8'($urandom);
      ready_i = (i < 5000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      step();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("final_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
